// File: rtl/ahb_core_bridge.sv
// Core valid/ready load/store port to AHB-Lite master: pipelined address/data
// stages, HREADY stalls, write lane steering, read extraction/extension, local error tokens.
module ahb_core_bridge (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA
);

   function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'd0:    return {4{wd[7:0]}};
         2'd1:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] extend_rdata(input logic [1:0] size, input logic [1:0] lane,
                                                input logic sgn, input logic [31:0] rd);
      logic [7:0]         b;
      logic [15:0]        h;
      logic signed [31:0] ext;
      case (lane)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'd0:    ext = {{24{sgn & b[7]}}, b};
         2'd1:    ext = {{16{sgn & h[15]}}, h};
         default: ext = rd;
      endcase
      return ext;
   endfunction

   // address stage (_p0)
   logic        r_vld_p0, r_err_p0, r_write_p0, r_signed_p0;
   logic [31:0] r_addr_p0, r_wdata_p0;
   logic [1:0]  r_size_p0;
   // data stage (_p1)
   logic        r_vld_p1, r_err_p1, r_write_p1, r_signed_p1;
   logic [1:0]  r_lane_p1, r_size_p1;
   logic [31:0] r_hwdata_p1;

   logic w_accept, w_bad;

   assign w_accept = req_valid & HREADY;
   assign w_bad    = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_vld_p0    <= 1'b0;
         r_vld_p1    <= 1'b0;
         r_hwdata_p1 <= '0;
      end else if (HREADY) begin
         r_vld_p0 <= req_valid;
         r_vld_p1 <= r_vld_p0;
         if (r_vld_p0 && r_write_p0 && !r_err_p0)
            r_hwdata_p1 <= steer_wdata(r_size_p0, r_wdata_p0);
      end
   end

   // payload registers carry no reset; every use is qualified by the stage valid
   always_ff @(posedge HCLK) begin
      if (w_accept) begin
         r_err_p0    <= w_bad;
         r_write_p0  <= req_write;
         r_addr_p0   <= req_addr;
         r_size_p0   <= req_size;
         r_signed_p0 <= req_signed;
         r_wdata_p0  <= req_wdata;
      end
      if (HREADY) begin
         r_err_p1    <= r_err_p0;
         r_write_p1  <= r_write_p0;
         r_lane_p1   <= r_addr_p0[1:0];
         r_size_p1   <= r_size_p0;
         r_signed_p1 <= r_signed_p0;
      end
   end

   assign req_ready = HREADY;
   assign HTRANS    = (r_vld_p0 && !r_err_p0) ? 2'b10 : 2'b00;
   assign HADDR     = r_vld_p0 ? r_addr_p0 : 32'h0;
   assign HWRITE    = r_vld_p0 & r_write_p0;
   assign HSIZE     = r_vld_p0 ? {1'b0, r_size_p0} : 3'b000;
   assign HBURST    = 3'b000;
   assign HWDATA    = r_hwdata_p1;

   assign rsp_valid = r_vld_p1 & HREADY;
   assign rsp_err   = r_vld_p1 & r_err_p1;
   assign rsp_rdata = (r_vld_p1 && !r_err_p1 && !r_write_p1) ?
                      extend_rdata(r_size_p1, r_lane_p1, r_signed_p1, HRDATA) : 32'h0;

endmodule

// File: doc/ahb_core_bridge.md
# ahb_core_bridge

Converts the processor's simple valid/ready load/store port into an AHB-Lite master, which drives the on-chip slaves including the block RAM. Address and data phases are fully pipelined, with one transfer per cycle at zero wait states. The bridge handles HREADY stalls, byte-lane steering of write data and extraction/extension of read data. Misaligned or illegal requests are answered locally with an error response and never reach the bus.

## Interface
- No parameters (32-bit address and data fixed).
- HCLK  input  1  system clock; all state on rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- req_valid  input  1  core request present.
- req_ready  output  1  request accepted on edge where req_valid && req_ready; equals HREADY.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  0 byte, 1 halfword, 2 word, 3 illegal.
- req_signed  input  1  loads: 1 sign-extend, 0 zero-extend.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  completion strobe, one per accepted request, in order.
- rsp_err  output  1  qualifies rsp_valid: misaligned or illegal size.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- HADDR  output  32  address phase.
- HTRANS  output  2  IDLE 2'b00 or NONSEQ 2'b10 only.
- HWRITE  output  1.
- HSIZE  output  3  {1'b0, req_size}.
- HBURST  output  3  constant 3'b000 (SINGLE).
- HWDATA  output  32  data phase, lane-steered.
- HREADY  input  1  system HREADY (mux of slave HREADYOUT).
- HRDATA  input  32  read data from selected slave.

## Operation
- Two register stages: address stage (a_valid, a_err, a_write, a_addr, a_size, a_signed, a_wdata) and data stage (d_valid, d_err, d_write, d_lane[1:0], d_size, d_signed, HWDATA).
- Edge with HREADY=1: data stage <= address stage; address stage <= new request if req_valid, else empty.
- Edge with HREADY=0: both stages hold. Address outputs remain stable throughout the stall.
- HTRANS=NONSEQ only when a_valid && !a_err, otherwise IDLE. HADDR/HWRITE/HSIZE come from the address stage. HADDR=0 when the stage is empty.
- Error check at acceptance:
  - size 3, or halfword with addr[0]=1, or word with addr[1:0]≠0 → a_err=1.
  - The request flows through the pipeline as a bus-IDLE token so responses stay in order.
- Write steering when entering data stage:
  - byte → wdata[7:0] replicated ×4.
  - half → wdata[15:0] ×2.
  - word → as is.
- Response:
  - rsp_valid = d_valid && HREADY (combinational); rsp_err = d_err.
  - Load: select byte/half of HRDATA at lane d_lane, extend per d_signed to 32 bits; word passes through.
  - Stores and errors: rsp_rdata = 0.
- HRESP is not used: slaves in this system never signal ERROR.

## Timing
- Reset (edge with HRESETn=0): both stages empty. HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Reset mid-transfer: in-flight requests are dropped with no response. The first request after reset is accepted on the first edge with HRESETn=1 and HREADY=1.
- Latency, zero wait: request accepted at edge N → NONSEQ in cycle N+1 → HWDATA valid and rsp_valid in cycle N+2 (sampled at edge N+2).
- Each wait cycle in a data phase adds one cycle. HREADY=0 during the address phase of the next transfer also delays it, because that address phase shares the stalled cycle.
- Throughput: back-to-back accepts give continuous NONSEQ with one response per cycle.
- Simultaneous events: acceptance and completion on the same edge are normal pipeline flow. A request with req_valid=1 while HREADY=0 is not accepted, and the core must hold it.
- Error token: rsp_valid with rsp_err=1 appears two cycles after acceptance, subject to HREADY like a real transfer.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x100 followed by word load from 0x100 → HTRANS NONSEQ/NONSEQ on consecutive cycles; load rsp_rdata=0xDEADBEEF two cycles after the load is accepted.
- Byte store 0x5A to 0x203 → HSIZE=0, HWDATA=0x5A5A5A5A. Byte load from 0x203 with HRDATA=0x80000000, signed → 0xFFFFFF80; unsigned → 0x00000080.
- Halfword load from 0x302 with HRDATA=0x8001_1234, signed → 0xFFFF8001.
- Slave holds HREADY=0 for 3 cycles during a load data phase with 2 queued requests → HADDR/HTRANS frozen, req_ready=0, exactly one rsp_valid when HREADY returns, order preserved.
- Word load to 0x102 and req_size=3 → HTRANS stays IDLE; rsp_valid with rsp_err=1, rsp_rdata=0, each two cycles after acceptance.
- HRESETn low for one edge while a store is in data phase → next cycle all outputs at reset values and no rsp_valid for the dropped store.
